// File: rtl/conv_stream_host.sv
// Host-side driver/collector for the conv_8_4 convolver: streams one loaded x/f
// batch out over valid/ready and captures the y result stream into a read buffer.
module conv_stream_host #(
   parameter int XSIZE = 8,
   parameter int FSIZE = 4,
   parameter int YSIZE = 5,
   parameter int DW    = 8,
   parameter int YW    = 18
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ld_wr_en,
   input  logic                       ld_sel,
   input  logic [$clog2(XSIZE)-1:0]   ld_addr,
   input  logic [DW-1:0]              ld_data,
   input  logic                       start,
   input  logic                       gap_x,
   input  logic                       gap_f,
   input  logic                       hold_y,
   output logic [DW-1:0]              m_data_x,
   output logic                       m_valid_x,
   input  logic                       m_ready_x,
   output logic [DW-1:0]              m_data_f,
   output logic                       m_valid_f,
   input  logic                       m_ready_f,
   input  logic [YW-1:0]              s_data_y,
   input  logic                       s_valid_y,
   output logic                       s_ready_y,
   input  logic [$clog2(YSIZE)-1:0]   rd_addr,
   output logic [YW-1:0]              rd_data,
   output logic                       busy,
   output logic                       done
);

   localparam int XAW = $clog2(XSIZE);
   localparam int FAW = $clog2(FSIZE);
   localparam int YAW = $clog2(YSIZE);
   localparam int XCW = XAW + 1;
   localparam int FCW = FAW + 1;
   localparam int YCW = YAW + 1;

   localparam logic [XCW-1:0] X_FULL  = XCW'(XSIZE);
   localparam logic [FCW-1:0] F_FULL  = FCW'(FSIZE);
   localparam logic [YCW-1:0] Y_FULL  = YCW'(YSIZE);
   localparam logic [XAW:0]   F_MOD   = (XAW+1)'(FSIZE);
   localparam logic [YAW:0]   Y_DEPTH = (YAW+1)'(YSIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [XCW-1:0] x_cnt_reg, x_cnt_next;
   logic [FCW-1:0] f_cnt_reg, f_cnt_next;
   logic [YCW-1:0] y_cnt_reg, y_cnt_next;
   logic           busy_reg, busy_next;
   logic           done_reg, done_next;

   logic [DW-1:0]  x_mem   [XSIZE];
   logic [DW-1:0]  f_mem   [FSIZE];
   logic [YW-1:0]  res_mem [YSIZE];

   logic           in_run;
   logic           enter_run;
   logic           all_full;
   logic           load_ok;
   logic           x_we, f_we;
   logic [FAW-1:0] f_wr_idx;
   logic [XAW-1:0] x_rd_idx;
   logic [FAW-1:0] f_rd_idx;
   logic [YAW-1:0] y_wr_idx;
   logic           x_fire, f_fire, y_fire;

   assign in_run    = (state_reg == RUN);
   assign enter_run = start && !in_run;
   assign all_full  = (x_cnt_reg == X_FULL) && (f_cnt_reg == F_FULL) && (y_cnt_reg == Y_FULL);

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)    state_next = RUN;
         RUN:     if (all_full) state_next = DONE;
         DONE:    if (start)    state_next = RUN;
         default:               state_next = IDLE;
      endcase
      busy_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;

   // ------------------------------------------------------------------
   // Stream handshakes: valid/ready are purely combinational so every
   // stream sustains one word per cycle with no bubble after acceptance.
   // ------------------------------------------------------------------
   assign m_valid_x = in_run && (x_cnt_reg < X_FULL) && !gap_x;
   assign m_valid_f = in_run && (f_cnt_reg < F_FULL) && !gap_f;
   assign s_ready_y = in_run && (y_cnt_reg < Y_FULL) && !hold_y;

   assign x_fire = m_valid_x && m_ready_x;
   assign f_fire = m_valid_f && m_ready_f;
   assign y_fire = s_valid_y && s_ready_y;

   // Saturated counters park the read index at 0 so it never leaves the array.
   assign x_rd_idx = (x_cnt_reg < X_FULL) ? x_cnt_reg[XAW-1:0] : '0;
   assign f_rd_idx = (f_cnt_reg < F_FULL) ? f_cnt_reg[FAW-1:0] : '0;
   assign y_wr_idx = y_cnt_reg[YAW-1:0];

   assign m_data_x = x_mem[x_rd_idx];
   assign m_data_f = f_mem[f_rd_idx];

   always_comb begin
      x_cnt_next = x_cnt_reg;
      f_cnt_next = f_cnt_reg;
      y_cnt_next = y_cnt_reg;
      if (enter_run) begin
         x_cnt_next = '0;
         f_cnt_next = '0;
         y_cnt_next = '0;
      end else begin
         if (x_fire && (x_cnt_reg != X_FULL)) x_cnt_next = x_cnt_reg + 1'b1;
         if (f_fire && (f_cnt_reg != F_FULL)) f_cnt_next = f_cnt_reg + 1'b1;
         if (y_fire && (y_cnt_reg != Y_FULL)) y_cnt_next = y_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt_reg <= '0;
         f_cnt_reg <= '0;
         y_cnt_reg <= '0;
      end else begin
         x_cnt_reg <= x_cnt_next;
         f_cnt_reg <= f_cnt_next;
         y_cnt_reg <= y_cnt_next;
      end
   end

   // ------------------------------------------------------------------
   // Sample buffers; contents deliberately survive reset so a batch can
   // be replayed after an abort without reloading.
   // ------------------------------------------------------------------
   assign load_ok  = ld_wr_en && !in_run;
   assign x_we     = load_ok && !ld_sel;
   assign f_we     = load_ok &&  ld_sel;
   assign f_wr_idx = FAW'({1'b0, ld_addr} % F_MOD);

   generate
      for (genvar gi = 0; gi < XSIZE; gi++) begin : g_x_mem
         always_ff @(posedge clk) begin
            if (x_we && (ld_addr == XAW'(gi)))
               x_mem[gi] <= ld_data;
         end
      end

      for (genvar gi = 0; gi < FSIZE; gi++) begin : g_f_mem
         always_ff @(posedge clk) begin
            if (f_we && (f_wr_idx == FAW'(gi)))
               f_mem[gi] <= ld_data;
         end
      end

      for (genvar gi = 0; gi < YSIZE; gi++) begin : g_res_mem
         always_ff @(posedge clk) begin
            if (y_fire && (y_wr_idx == YAW'(gi)))
               res_mem[gi] <= s_data_y;
         end
      end
   endgenerate

   assign rd_data = ({1'b0, rd_addr} < Y_DEPTH) ? res_mem[rd_addr] : '0;

endmodule

// File: tb/tb_conv_stream_host.sv
// Directed bench for conv_stream_host: full-rate streaming, throttled streaming,
// result capture, overflow rejection, mid-run reset and reload-in-DONE.
module tb_conv_stream_host;

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_wr_en;
   logic          ld_sel;
   logic [2:0]    ld_addr;
   logic [7:0]    ld_data;
   logic          start;
   logic          gap_x, gap_f, hold_y;
   logic [7:0]    m_data_x, m_data_f;
   logic          m_valid_x, m_ready_x;
   logic          m_valid_f, m_ready_f;
   logic [17:0]   s_data_y;
   logic          s_valid_y, s_ready_y;
   logic [2:0]    rd_addr;
   logic [17:0]   rd_data;
   logic          busy, done;

   int tests_run = 0;
   int fails     = 0;

   logic signed [7:0]  xv    [8];
   logic signed [7:0]  fv    [4];
   logic signed [17:0] yv    [5];
   logic signed [17:0] yfast [5];

   always #5 clk = ~clk;

   conv_stream_host #(.XSIZE(8), .FSIZE(4), .YSIZE(5), .DW(8), .YW(18)) dut (
      .clk       (clk),
      .reset     (reset),
      .ld_wr_en  (ld_wr_en),
      .ld_sel    (ld_sel),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .start     (start),
      .gap_x     (gap_x),
      .gap_f     (gap_f),
      .hold_y    (hold_y),
      .m_data_x  (m_data_x),
      .m_valid_x (m_valid_x),
      .m_ready_x (m_ready_x),
      .m_data_f  (m_data_f),
      .m_valid_f (m_valid_f),
      .m_ready_f (m_ready_f),
      .s_data_y  (s_data_y),
      .s_valid_y (s_valid_y),
      .s_ready_y (s_ready_y),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      ld_wr_en = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; start = 0;
      gap_x = 0; gap_f = 0; hold_y = 0; m_ready_x = 0; m_ready_f = 0;
      s_data_y = 0; s_valid_y = 0; rd_addr = 0;
   endtask

   task automatic do_reset;
      clear_inputs();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic load_batch;
      for (int i = 0; i < 8; i++) begin
         ld_wr_en = 1; ld_sel = 0; ld_addr = 3'(i); ld_data = xv[i];
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         ld_wr_en = 1; ld_sel = 1; ld_addr = 3'(i); ld_data = fv[i];
         tick();
      end
      ld_wr_en = 0;
   endtask

   task automatic pulse_start;
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic check_results(input string name, input logic signed [17:0] exp_y [5]);
      for (int i = 0; i < 5; i++) begin
         rd_addr = 3'(i);
         #1;
         tests_run++;
         if (rd_data !== exp_y[i]) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, i, $signed(rd_data), exp_y[i]);
         end
      end
   endtask

   // Full-rate batch: entered in RUN with counters at 0; all streams ready.
   task automatic run_fast(input string name);
      for (int c = 0; c < 8; c++) begin
         m_ready_x = 1; m_ready_f = 1; gap_x = 0; gap_f = 0; hold_y = 0;
         s_valid_y = (c < 5);
         s_data_y  = (c < 5) ? yfast[c] : 18'd0;
         #1;
         tests_run++;
         if (m_valid_x !== 1'b1 || m_data_x !== xv[c]) begin
            fails++;
            $display("FAIL %s_x[%0d]: valid=%b data=%0d expected valid=1 data=%0d",
                     name, c, m_valid_x, $signed(m_data_x), xv[c]);
         end
         tests_run++;
         if (m_valid_f !== (c < 4) || (c < 4 && m_data_f !== fv[c])) begin
            fails++;
            $display("FAIL %s_f[%0d]: valid=%b data=%0d expected valid=%b data=%0d",
                     name, c, m_valid_f, $signed(m_data_f), (c < 4), (c < 4) ? fv[c] : 8'sd0);
         end
         tests_run++;
         if (s_ready_y !== (c < 5)) begin
            fails++;
            $display("FAIL %s_ready_y[%0d]: got %b expected %b", name, c, s_ready_y, (c < 5));
         end
         tick();
      end
      s_valid_y = 0;
      #1;
      tests_run++;
      if (m_valid_x !== 1'b0 || m_valid_f !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL %s_tail: vx=%b vf=%b busy=%b done=%b expected 0 0 1 0",
                  name, m_valid_x, m_valid_f, busy, done);
      end
      tick();
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_done: busy=%b done=%b expected busy=0 done=1", name, busy, done);
      end
      check_results({name, "_res"}, yfast);
   endtask

   task automatic test_reset;
      clear_inputs();
      reset = 1;
      tick();
      tick();
      tests_run++;
      if (busy !== 0 || done !== 0 || m_valid_x !== 0 || m_valid_f !== 0 || s_ready_y !== 0) begin
         fails++;
         $display("FAIL reset_state: busy=%b done=%b vx=%b vf=%b ry=%b expected all 0",
                  busy, done, m_valid_x, m_valid_f, s_ready_y);
      end
      reset = 0;
      tick();
   endtask

   task automatic test_stream_basic;
      load_batch();
      tests_run++;
      if (busy !== 0 || done !== 0) begin
         fails++;
         $display("FAIL idle_after_load: busy=%b done=%b expected 0 0", busy, done);
      end
      pulse_start();
      run_fast("basic");
   endtask

   // Random throttling on all three streams; a load attempted during RUN must be ignored.
   task automatic test_random_handshake;
      int  xi, fi, yi, cyc;
      logic exp_vx, exp_vf, exp_ry;
      xi = 0; fi = 0; yi = 0; cyc = 0;
      pulse_start();
      while (!(xi == 8 && fi == 4 && yi == 5) && cyc < 300) begin
         m_ready_x = 1'($urandom_range(0, 1));
         m_ready_f = 1'($urandom_range(0, 1));
         gap_x     = ($urandom_range(0, 3) == 0);
         gap_f     = ($urandom_range(0, 3) == 0);
         hold_y    = ($urandom_range(0, 2) == 0);
         s_valid_y = 1'($urandom_range(0, 1));
         s_data_y  = (yi < 5) ? yv[yi] : 18'd999;
         ld_wr_en = 1; ld_sel = 0; ld_addr = 3'd1; ld_data = 8'd99;
         #1;
         exp_vx = (xi < 8) && !gap_x;
         exp_vf = (fi < 4) && !gap_f;
         exp_ry = (yi < 5) && !hold_y;
         tests_run++;
         if (m_valid_x !== exp_vx || (xi < 8 && m_data_x !== xv[xi])) begin
            fails++;
            $display("FAIL rand_x cyc%0d: valid=%b data=%0d expected valid=%b data=%0d",
                     cyc, m_valid_x, $signed(m_data_x), exp_vx, (xi < 8) ? xv[xi] : 8'sd0);
         end
         tests_run++;
         if (m_valid_f !== exp_vf || (fi < 4 && m_data_f !== fv[fi])) begin
            fails++;
            $display("FAIL rand_f cyc%0d: valid=%b data=%0d expected valid=%b data=%0d",
                     cyc, m_valid_f, $signed(m_data_f), exp_vf, (fi < 4) ? fv[fi] : 8'sd0);
         end
         tests_run++;
         if (s_ready_y !== exp_ry) begin
            fails++;
            $display("FAIL rand_ready_y cyc%0d: got %b expected %b", cyc, s_ready_y, exp_ry);
         end
         if (exp_vx && m_ready_x) xi++;
         if (exp_vf && m_ready_f) fi++;
         if (exp_ry && s_valid_y) yi++;
         tick();
         cyc++;
      end
      clear_inputs();
      tests_run++;
      if (cyc >= 300) begin
         fails++;
         $display("FAIL rand_timeout: xi=%0d fi=%0d yi=%0d expected 8 4 5", xi, fi, yi);
      end
      #1;
      tests_run++;
      if (busy !== 1 || done !== 0) begin
         fails++;
         $display("FAIL rand_last_cycle: busy=%b done=%b expected 1 0", busy, done);
      end
      tick();
      tests_run++;
      if (busy !== 0 || done !== 1) begin
         fails++;
         $display("FAIL rand_done: busy=%b done=%b expected 0 1", busy, done);
      end
      check_results("rand_res", yv);
   endtask

   task automatic test_y_overflow;
      s_valid_y = 1; s_data_y = 18'd999;
      #1;
      tests_run++;
      if (s_ready_y !== 0) begin
         fails++;
         $display("FAIL ovf_done_ready: got %b expected 0", s_ready_y);
      end
      tick();
      tick();
      do_reset();
      s_valid_y = 1; s_data_y = 18'd999;
      #1;
      tests_run++;
      if (s_ready_y !== 0) begin
         fails++;
         $display("FAIL ovf_idle_ready: got %b expected 0", s_ready_y);
      end
      tick();
      tick();
      s_valid_y = 0;
      check_results("ovf_res", yv);
   endtask

   task automatic test_reset_abort;
      pulse_start();
      for (int c = 0; c < 3; c++) begin
         m_ready_x = 1; m_ready_f = 0;
         #1;
         tests_run++;
         if (m_valid_x !== 1 || m_data_x !== xv[c]) begin
            fails++;
            $display("FAIL abort_pre_x[%0d]: valid=%b data=%0d expected 1 %0d",
                     c, m_valid_x, $signed(m_data_x), xv[c]);
         end
         tick();
      end
      reset = 1;
      tick();
      tests_run++;
      if (m_valid_x !== 0 || m_valid_f !== 0 || s_ready_y !== 0 || busy !== 0 || done !== 0) begin
         fails++;
         $display("FAIL abort_state: vx=%b vf=%b ry=%b busy=%b done=%b expected all 0",
                  m_valid_x, m_valid_f, s_ready_y, busy, done);
      end
      reset = 0;
      m_ready_x = 0;
      tick();
      pulse_start();
      run_fast("restart");
   endtask

   task automatic test_reload;
      ld_wr_en = 1; ld_sel = 0; ld_addr = 3'd0; ld_data = 8'd1;
      start = 1;
      tick();
      ld_wr_en = 0; start = 0;
      xv[0] = 8'sd1;
      tests_run++;
      if (busy !== 1 || done !== 0) begin
         fails++;
         $display("FAIL reload_state: busy=%b done=%b expected 1 0", busy, done);
      end
      run_fast("reload");
   endtask

   initial begin
      xv    = '{8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50, 8'sd60, 8'sd70, 8'sd80};
      fv    = '{8'sd10, 8'sd20, -8'sd30, 8'sd40};
      yv    = '{-18'sd2800, 18'sd3600, 18'sd400, 18'sd1600, 18'sd2800};
      yfast = '{18'sd11, -18'sd22, 18'sd33, -18'sd44, 18'sd55};
      reset = 0;
      clear_inputs();
      test_reset();
      test_stream_basic();
      test_random_handshake();
      test_y_overflow();
      test_reset_abort();
      test_reload();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
